alu_exec_unit: RTL and testbench

//  Parametrised successor to the combinational ALU control decode: decodes aluOp/funct, executes the op and registers
//  the result behind a valid/ready handshake. Adds iterative mult/multu/div/divu with HI/LO and mfhi/mflo.

---
 rtl/alu_exec_if.sv | 32 +++
 rtl/alu_exec_unit.sv | 197 +++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_if.sv
// Handshake bundle between the EX-stage control and the ALU execution unit.
// The master side presents operations and consumes results; the slave side is the unit.
interface alu_exec_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
);
    logic               in_valid;
    logic               in_ready;
    logic [2:0]         alu_op;
    logic [5:0]         funct;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   operand_a;
    logic [WIDTH-1:0]   operand_b;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   result;
    logic               zero;
    logic               illegal;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic               busy;

    modport master (
        output in_valid, alu_op, funct, shamt, operand_a, operand_b, out_ready,
        input  in_ready, out_valid, result, zero, illegal, hi, lo, busy
    );

    modport slave (
        input  in_valid, alu_op, funct, shamt, operand_a, operand_b, out_ready,
        output in_ready, out_valid, result, zero, illegal, hi, lo, busy
    );
endinterface

// File: rtl/alu_exec_unit.sv
// EX-stage ALU: decodes alu_op/funct, registers the result behind valid/ready, and runs
// iterative shift-add multiply and restoring divide into HI/LO.
module alu_exec_unit #(
    parameter int WIDTH      = 32,
    parameter int SHAMT_W    = 5,
    parameter int MUL_DIV_EN = 1
) (
    input  logic     clk,
    input  logic     reset,
    alu_exec_if.slave bus
);
    localparam logic MD = (MUL_DIV_EN != 0);
    localparam int   CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {S_IDLE, S_EXEC, S_MUL, S_DIV, S_DONE} state_t;

    state_t state_reg, state_next;

    logic [2:0]         alu_op_reg;
    logic [5:0]         funct_reg;
    logic [SHAMT_W-1:0] shamt_reg;
    logic [WIDTH-1:0]   op_a_reg, op_b_reg;
    logic [CW-1:0]      count_reg;
    logic [2*WIDTH-1:0] acc_reg, mcand_reg;
    logic [WIDTH-1:0]   mplier_reg, rem_reg, quo_reg, divisor_reg;
    logic               neg_q_reg, neg_r_reg;
    logic [WIDTH-1:0]   result_reg, hi_reg, lo_reg;
    logic               zero_reg, illegal_reg;

    logic in_ready, accept, last;
    logic is_mul, is_div, is_signed;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ill;

    assign in_ready = (state_reg == S_IDLE);
    assign accept   = bus.in_valid && in_ready;
    assign last     = (count_reg == CW'(WIDTH));

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? -v : v;
    endfunction

    // Only mult/div leave the single-cycle path; with MUL_DIV_EN=0 they decode as illegal in EXEC.
    always_comb begin
        is_mul    = 1'b0;
        is_div    = 1'b0;
        is_signed = 1'b0;
        if (MD && bus.alu_op == 3'b100) begin
            case (bus.funct)
                6'b011000: begin is_mul = 1'b1; is_signed = 1'b1; end
                6'b011001: is_mul = 1'b1;
                6'b011010: begin is_div = 1'b1; is_signed = 1'b1; end
                6'b011011: is_div = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (alu_op_reg)
            3'b000: alu_res = op_a_reg + op_b_reg;
            3'b001: alu_res = op_a_reg - op_b_reg;
            3'b010: alu_res = op_a_reg | op_b_reg;
            3'b011: alu_res = op_a_reg & op_b_reg;
            3'b101: alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a_reg) < $signed(op_b_reg))};
            3'b110: alu_res = {{(WIDTH-1){1'b0}}, (op_a_reg < op_b_reg)};
            3'b111: alu_res = op_a_reg ^ op_b_reg;
            default: begin
                case (funct_reg)
                    6'b100000: alu_res = op_a_reg + op_b_reg;
                    6'b100010: alu_res = op_a_reg - op_b_reg;
                    6'b100100: alu_res = op_a_reg & op_b_reg;
                    6'b100101: alu_res = op_a_reg | op_b_reg;
                    6'b100110: alu_res = op_a_reg ^ op_b_reg;
                    6'b100111: alu_res = ~(op_a_reg | op_b_reg);
                    6'b000000: alu_res = op_b_reg << shamt_reg;
                    6'b000010: alu_res = op_b_reg >> shamt_reg;
                    6'b000011: alu_res = $signed(op_b_reg) >>> shamt_reg;
                    6'b101010: alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a_reg) < $signed(op_b_reg))};
                    6'b101011: alu_res = {{(WIDTH-1){1'b0}}, (op_a_reg < op_b_reg)};
                    6'b010000: if (MD) alu_res = hi_reg; else alu_ill = 1'b1;
                    6'b010010: if (MD) alu_res = lo_reg; else alu_ill = 1'b1;
                    default:   alu_ill = 1'b1;
                endcase
            end
        endcase
    end

    // One restoring-division step: shift in the next dividend bit, subtract if it fits.
    logic [WIDTH:0]   div_shift;
    logic             div_fits;
    logic [WIDTH-1:0] div_sub;
    assign div_shift = {rem_reg, quo_reg[WIDTH-1]};
    assign div_fits  = (div_shift >= {1'b0, divisor_reg});
    assign div_sub   = div_shift[WIDTH-1:0] - divisor_reg;

    always_ff @(posedge clk) begin
        if (reset) state_reg <= S_IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (accept) state_next = is_mul ? S_MUL : (is_div ? S_DIV : S_EXEC);
            S_EXEC: state_next = S_DONE;
            S_MUL,
            S_DIV:  if (last) state_next = S_DONE;
            S_DONE: if (bus.out_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result_reg  <= '0;
            zero_reg    <= 1'b0;
            illegal_reg <= 1'b0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            count_reg   <= '0;
        end else begin
            case (state_reg)
                S_IDLE: if (accept) begin
                    alu_op_reg  <= bus.alu_op;
                    funct_reg   <= bus.funct;
                    shamt_reg   <= bus.shamt;
                    op_a_reg    <= bus.operand_a;
                    op_b_reg    <= bus.operand_b;
                    count_reg   <= '0;
                    acc_reg     <= '0;
                    mcand_reg   <= {{WIDTH{1'b0}}, mag(bus.operand_a, is_signed)};
                    mplier_reg  <= mag(bus.operand_b, is_signed);
                    rem_reg     <= '0;
                    quo_reg     <= mag(bus.operand_a, is_signed);
                    divisor_reg <= mag(bus.operand_b, is_signed);
                    neg_q_reg   <= is_signed && (bus.operand_a[WIDTH-1] ^ bus.operand_b[WIDTH-1]);
                    neg_r_reg   <= is_signed && bus.operand_a[WIDTH-1];
                end
                S_EXEC: begin
                    result_reg  <= alu_res;
                    zero_reg    <= (alu_res == '0);
                    illegal_reg <= alu_ill;
                end
                S_MUL: if (!last) begin
                    if (mplier_reg[0]) acc_reg <= acc_reg + mcand_reg;
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_reg >> 1;
                    count_reg  <= count_reg + CW'(1);
                end else begin
                    {hi_reg, lo_reg} <= neg_q_reg ? -acc_reg : acc_reg;
                    result_reg  <= '0;
                    zero_reg    <= 1'b1;
                    illegal_reg <= 1'b0;
                end
                S_DIV: if (!last) begin
                    rem_reg   <= div_fits ? div_sub : div_shift[WIDTH-1:0];
                    quo_reg   <= {quo_reg[WIDTH-2:0], div_fits};
                    count_reg <= count_reg + CW'(1);
                end else begin
                    // Divide by zero reports the raw dividend, not a sign-corrected magnitude.
                    if (divisor_reg == '0) begin
                        lo_reg <= '1;
                        hi_reg <= op_a_reg;
                    end else begin
                        lo_reg <= neg_q_reg ? -quo_reg : quo_reg;
                        hi_reg <= neg_r_reg ? -rem_reg : rem_reg;
                    end
                    result_reg  <= '0;
                    zero_reg    <= 1'b1;
                    illegal_reg <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_reg == S_DONE);
    assign bus.result    = result_reg;
    assign bus.zero      = zero_reg;
    assign bus.illegal   = illegal_reg;

    generate
        if (MUL_DIV_EN != 0) begin : g_md
            assign bus.hi   = hi_reg;
            assign bus.lo   = lo_reg;
            assign bus.busy = (state_reg == S_MUL) || (state_reg == S_DIV);
        end else begin : g_no_md
            assign bus.hi   = '0;
            assign bus.lo   = '0;
            assign bus.busy = 1'b0;
        end
    endgenerate
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit: single-cycle ops, mult/div, backpressure, reset mid-op.
module tb_alu_exec_unit;
    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    alu_exec_if #(.WIDTH(32), .SHAMT_W(5)) alu_bus ();

    alu_exec_unit #(.WIDTH(32), .SHAMT_W(5), .MUL_DIV_EN(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (alu_bus)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input string tag, input logic [2:0] op, input logic [5:0] fn,
                         input logic [4:0] sh, input logic [31:0] a, input logic [31:0] b);
        int guard = 0;
        alu_bus.in_valid  = 1'b1;
        alu_bus.alu_op    = op;
        alu_bus.funct     = fn;
        alu_bus.shamt     = sh;
        alu_bus.operand_a = a;
        alu_bus.operand_b = b;
        while (!alu_bus.in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        chk({tag, " accept timeout"}, 64'(guard < 100), 64'd1);
        @(posedge clk); #1;
        alu_bus.in_valid = 1'b0;
    endtask

    // Waits for out_valid after an accept, checking latency and busy/in_ready during iteration.
    task automatic wait_done(input string tag, input int exp_lat);
        int   cyc = 0;
        logic busy_all = 1'b1;
        logic rdy_seen = 1'b0;
        while (!alu_bus.out_valid && cyc < 100) begin
            busy_all &= alu_bus.busy;
            rdy_seen |= alu_bus.in_ready;
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, " latency"}, 64'(cyc), 64'(exp_lat));
        if (exp_lat > 1) begin
            chk({tag, " busy held"}, 64'(busy_all), 64'd1);
            chk({tag, " in_ready low"}, 64'(rdy_seen), 64'd0);
        end
    endtask

    task automatic check_res(input string tag, input logic [31:0] res, input logic z, input logic ill);
        $display("op %-10s result=%h zero=%0b illegal=%0b hi=%h lo=%h", tag,
                 alu_bus.result, alu_bus.zero, alu_bus.illegal, alu_bus.hi, alu_bus.lo);
        chk({tag, " result"}, 64'(alu_bus.result), 64'(res));
        chk({tag, " zero"}, 64'(alu_bus.zero), 64'(z));
        chk({tag, " illegal"}, 64'(alu_bus.illegal), 64'(ill));
    endtask

    task automatic consume();
        @(posedge clk); #1;
    endtask

    task automatic alu1(input string tag, input logic [2:0] op, input logic [5:0] fn, input logic [4:0] sh,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input logic z, input logic ill);
        issue(tag, op, fn, sh, a, b);
        wait_done(tag, 1);
        check_res(tag, res, z, ill);
        consume();
    endtask

    task automatic muldiv(input string tag, input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        issue(tag, 3'b100, fn, 5'd0, a, b);
        wait_done(tag, 33);
        check_res(tag, 32'h0, 1'b1, 1'b0);
        chk({tag, " hi"}, 64'(alu_bus.hi), 64'(exp_hi));
        chk({tag, " lo"}, 64'(alu_bus.lo), 64'(exp_lo));
        consume();
    endtask

    initial begin
        reset             = 1'b1;
        alu_bus.in_valid  = 1'b0;
        alu_bus.out_ready = 1'b1;
        alu_bus.alu_op    = 3'b000;
        alu_bus.funct     = 6'd0;
        alu_bus.shamt     = 5'd0;
        alu_bus.operand_a = 32'd0;
        alu_bus.operand_b = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst out_valid", 64'(alu_bus.out_valid), 64'd0);
        chk("rst result", 64'(alu_bus.result), 64'd0);
        chk("rst hi", 64'(alu_bus.hi), 64'd0);
        chk("rst lo", 64'(alu_bus.lo), 64'd0);
        chk("rst busy", 64'(alu_bus.busy), 64'd0);
        chk("rst in_ready", 64'(alu_bus.in_ready), 64'd1);
        reset = 1'b0;

        // Single-cycle ops
        alu1("add_wrap", 3'b000, 6'd0,      5'd0,  32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b0, 1'b0);
        alu1("sub_zero", 3'b100, 6'b100010, 5'd0,  32'd5,        32'd5,        32'h0,        1'b1, 1'b0);
        alu1("sra",      3'b100, 6'b000011, 5'd4,  32'h0,        32'h80000000, 32'hF8000000, 1'b0, 1'b0);
        alu1("slt_r",    3'b100, 6'b101010, 5'd0,  32'hFFFFFFFF, 32'h1,        32'h1,        1'b0, 1'b0);
        alu1("slt_op",   3'b101, 6'd0,      5'd0,  32'hFFFFFFFF, 32'h1,        32'h1,        1'b0, 1'b0);
        alu1("sltu",     3'b100, 6'b101011, 5'd0,  32'hFFFFFFFF, 32'h1,        32'h0,        1'b1, 1'b0);
        alu1("illegal",  3'b100, 6'b111111, 5'd0,  32'd5,        32'd3,        32'h0,        1'b1, 1'b1);
        alu1("nor",      3'b100, 6'b100111, 5'd0,  32'hF0F0F0F0, 32'h0F0F0000, 32'h00000F0F, 1'b0, 1'b0);
        alu1("sll",      3'b100, 6'b000000, 5'd31, 32'h0,        32'h1,        32'h80000000, 1'b0, 1'b0);
        alu1("srl",      3'b100, 6'b000010, 5'd31, 32'h0,        32'h80000000, 32'h1,        1'b0, 1'b0);
        alu1("xor_op",   3'b111, 6'd0,      5'd0,  32'hFF00FF00, 32'h0FF00FF0, 32'hF0F0F0F0, 1'b0, 1'b0);
        alu1("and_op",   3'b011, 6'd0,      5'd0,  32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 1'b0, 1'b0);
        alu1("or_op",    3'b010, 6'd0,      5'd0,  32'h00F0000F, 32'h0F000F00, 32'h0FF00F0F, 1'b0, 1'b0);

        // Multiply / divide
        muldiv("mult",     6'b011000, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB);
        alu1("mfhi",     3'b100, 6'b010000, 5'd0, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b0);
        alu1("mflo",     3'b100, 6'b010010, 5'd0, 32'h0, 32'h0, 32'hFFFFFFEB, 1'b0, 1'b0);
        muldiv("multu",    6'b011001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        muldiv("div",      6'b011010, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
        muldiv("divu_by0", 6'b011011, 32'd7,        32'd0,        32'd7,        32'hFFFFFFFF);
        muldiv("div_by0",  6'b011010, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF);
        muldiv("divu",     6'b011011, 32'd100,      32'd7,        32'd2,        32'd14);
        muldiv("div_ovf",  6'b011010, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000);

        // Backpressure: result held while out_ready is low
        alu_bus.out_ready = 1'b0;
        issue("bp_add", 3'b000, 6'd0, 5'd0, 32'd2, 32'd3);
        wait_done("bp_add", 1);
        for (int i = 0; i < 5; i++) begin
            chk("bp result", 64'(alu_bus.result), 64'd5);
            chk("bp out_valid", 64'(alu_bus.out_valid), 64'd1);
            chk("bp in_ready", 64'(alu_bus.in_ready), 64'd0);
            @(posedge clk); #1;
        end
        $display("op %-10s result=%h held 5 cycles", "bp_add", alu_bus.result);
        alu_bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp release in_ready", 64'(alu_bus.in_ready), 64'd1);
        muldiv("mult_hi", 6'b011000, 32'h00010000, 32'h00030000, 32'h3, 32'h0);
        alu1("mfhi_new", 3'b100, 6'b010000, 5'd0, 32'h0, 32'h0, 32'h3, 1'b0, 1'b0);

        // Reset partway through a divide (lo is non-zero going in)
        muldiv("div_pre", 6'b011010, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
        issue("div_rst", 3'b100, 6'b011010, 5'd0, 32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        #1;
        chk("mid-div busy", 64'(alu_bus.busy), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        $display("op %-10s reset mid-op out_valid=%0b in_ready=%0b hi=%h lo=%h", "div_rst",
                 alu_bus.out_valid, alu_bus.in_ready, alu_bus.hi, alu_bus.lo);
        chk("rst2 out_valid", 64'(alu_bus.out_valid), 64'd0);
        chk("rst2 in_ready", 64'(alu_bus.in_ready), 64'd1);
        chk("rst2 busy", 64'(alu_bus.busy), 64'd0);
        chk("rst2 hi", 64'(alu_bus.hi), 64'd0);
        chk("rst2 lo", 64'(alu_bus.lo), 64'd0);
        alu1("post_rst", 3'b000, 6'd0, 5'd0, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
